// File: rtl/seq_divider_32.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero completes immediately with a flag.
module seq_divider_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] q_r, r_r, d_r;
   logic             dz_r;
   logic             last;

   logic [WIDTH:0]   t;
   logic [WIDTH:0]   diff;
   logic             borrow;

   // R < D holds throughout, so T - D never exceeds WIDTH+1 bits and
   // the top bit of the difference is set exactly when T < D.
   assign t      = {r_r, q_r[WIDTH-1]};
   assign diff   = t - {1'b0, d_r};
   assign borrow = diff[WIDTH];
   assign last   = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) state_nx = (divisor == '0) ? DONE : RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         q_r   <= '0;
         r_r   <= '0;
         d_r   <= '0;
         dz_r  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && divisor != '0) begin
                  q_r   <= dividend;
                  d_r   <= divisor;
                  r_r   <= '0;
                  count <= '0;
                  dz_r  <= 1'b0;
               end else if (start) begin
                  q_r   <= '1;
                  r_r   <= dividend;
                  dz_r  <= 1'b1;
               end
            end
            RUN: begin
               q_r   <= {q_r[WIDTH-2:0], ~borrow};
               r_r   <= borrow ? t[WIDTH-1:0] : diff[WIDTH-1:0];
               count <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign quotient    = q_r;
   assign remainder   = r_r;
   assign div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: directed cases, abort by reset,
// back-to-back starts and random pairs checked against a reference model.
module tb_seq_divider_32;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] dvd;
      logic [W-1:0] dsr;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seq_divider_32 #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] dvd,
                           input logic [W-1:0] dsr);
      exp_t e;
      e.dvd = dvd;
      e.dsr = dsr;
      if (dsr == '0) begin
         e.q  = '1;
         e.r  = dvd;
         e.dz = 1'b1;
      end else begin
         e.q  = dvd / dsr;
         e.r  = dvd % dsr;
         e.dz = 1'b0;
      end
      sb.push_back(e);
   endtask

   task automatic cmp_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_q"}, 64'(quotient), 64'(e.q));
      check({tag, "_r"}, 64'(remainder), 64'(e.r));
      check({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
      if (!e.dz) begin
         check({tag, "_inv"},
               64'(quotient) * 64'(e.dsr) + 64'(remainder),
               64'(e.dvd));
         check({tag, "_rlt"}, 64'(remainder < e.dsr), 64'd1);
      end
   endtask

   // poke >= 0: re-pulse start with other operands that many cycles in
   task automatic do_div(input string tag,
                         input logic [W-1:0] dvd,
                         input logic [W-1:0] dsr,
                         input int poke);
      int n;
      int lat;
      lat = (dsr == '0) ? 0 : W;
      push_exp(dvd, dsr);
      dividend = dvd;
      divisor  = dsr;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 100) begin
         if (n == poke) begin
            start    = 1'b1;
            dividend = 32'd50;
            divisor  = 32'd5;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'(lat));
      cmp_result(tag);
      tick();
      check({tag, "_pulse"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      logic [W-1:0] hq, hr;

      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_q", 64'(quotient), 64'd0);
      check("rst_r", 64'(remainder), 64'd0);
      check("rst_dz", 64'(div_by_zero), 64'd0);
      reset = 1'b0;
      tick();

      do_div("d100_7", 32'd100, 32'd7, -1);
      do_div("max_1", 32'hFFFF_FFFF, 32'd1, -1);
      do_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      do_div("dz5", 32'd5, 32'd0, -1);
      do_div("ign", 32'd3, 32'd10, 9);

      hq = quotient;
      hr = remainder;
      repeat (3) tick();
      check("hold_q", 64'(quotient), 64'd0);
      check("hold_r", 64'(remainder), 64'd3);
      check("hold_chg", 64'({hq, hr}), 64'({quotient, remainder}));

      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_q", 64'(quotient), 64'd0);
      check("abort_r", 64'(remainder), 64'd0);
      check("abort_dz", 64'(div_by_zero), 64'd0);
      reset = 1'b0;
      tick();
      check("abort_idle", 64'(busy), 64'd0);
      do_div("d1000_3", 32'd1000, 32'd3, -1);

      push_exp(32'd77, 32'd7);
      dividend = 32'd77;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("b2b1_lat", 64'(n), 64'(W));
      cmp_result("b2b1");
      push_exp(32'd200, 32'd9);
      dividend = 32'd200;
      divisor  = 32'd9;
      tick();
      check("b2b_gap", 64'(busy), 64'd0);
      tick();
      start = 1'b0;
      check("b2b_acc", 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("b2b2_lat", 64'(n), 64'(W));
      cmp_result("b2b2");
      tick();

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         case (i % 4)
            0: b = W'($urandom_range(1, 15));
            1: b = $urandom >> $urandom_range(0, 31);
            2: b = a + W'($urandom_range(0, 3));
            default: b = $urandom;
         endcase
         if (b == '0) b = 32'd1;
         do_div("rnd", a, b, -1);
      end

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
